seq_ctx_sched: RTL and testbench

Round-robin scheduler that time-shares one 4-state sequence-tracking FSM among N_CH serial-bit requesters. Each channel's 2-bit FSM state is held in a context register. The state is loaded into the shared working register when the channel is granted and written back when its burst ends, so every channel sees an uninterrupted FSM. The block sits between the per-channel bit sources and downstream match consumers.

---
 rtl/seq_ctx_sched.sv | 159 +++++++++++++++
 tb/tb_seq_ctx_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctx_sched.sv
// Round-robin scheduler time-sharing one 4-state sequence FSM across N_CH serial channels.
// Optional per-channel match statistics are built when SEQ_CTX_SCHED_STATS_EN is defined.
module seq_ctx_sched #(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned CW        = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] bit_in,
  input  logic [N_CH-1:0] last,
  input  logic [N_CH-1:0] ctx_clr,
  output logic [N_CH-1:0] gnt,
  output logic            out_valid,
  output logic [CW-1:0]   out_ch,
  output logic [1:0]      out_state,
  output logic            out_y,
  input  logic [CW-1:0]   stat_sel,
  output logic [15:0]     stat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_SAVE} sched_e;

  sched_e          r_state;
  logic [CW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_g;
  logic [1:0]      r_ctx [N_CH];
  logic [1:0]      r_work;
  logic [7:0]      r_cnt;
  logic [N_CH-1:0] r_gnt;
  logic            r_valid;
  logic [CW-1:0]   r_out_ch;
  logic [1:0]      r_out_state;
  logic            r_out_y;

  logic [CW-1:0]   w_idx;
  logic [CW-1:0]   w_pick;
  logic            w_any;
  logic            w_acc;
  logic [1:0]      w_start;
  logic [1:0]      w_next;
  logic            w_exit;

  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic c);
    case (s)
      2'b00:   fsm_next = c ? 2'b01 : 2'b00;
      2'b01:   fsm_next = c ? 2'b01 : 2'b11;
      2'b10:   fsm_next = c ? 2'b10 : 2'b00;
      default: fsm_next = c ? 2'b10 : 2'b11;
    endcase
  endfunction

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_idx = CW'((32'(r_rr_ptr) + k) % N_CH);
      if (!w_any && req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // A clear on the running channel restarts its sequence before this cycle's bit.
  always_comb begin
    w_acc   = req[r_g];
    w_start = ctx_clr[r_g] ? 2'b00 : r_work;
    w_next  = fsm_next(w_start, bit_in[r_g]);
    w_exit  = !w_acc || last[r_g] || (({1'b0, r_cnt} + 9'd1) == 9'(MAX_BURST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_g         <= '0;
      r_work      <= 2'b00;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_valid     <= 1'b0;
      r_out_ch    <= '0;
      r_out_state <= 2'b00;
      r_out_y     <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) r_ctx[i] <= 2'b00;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g     <= w_pick;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_work  <= r_ctx[r_g];
          r_cnt   <= '0;
          r_gnt   <= {{(N_CH-1){1'b0}}, 1'b1} << r_g;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_work <= w_acc ? w_next : w_start;
          if (w_acc) begin
            r_cnt       <= r_cnt + 8'd1;
            r_valid     <= 1'b1;
            r_out_ch    <= r_g;
            r_out_state <= w_next;
            r_out_y     <= &w_next;
          end
          if (w_exit) begin
            r_gnt   <= '0;
            r_state <= S_SAVE;
          end
        end
        default: begin
          r_ctx[r_g] <= r_work;
          r_rr_ptr   <= (r_g == CW'(N_CH - 1)) ? '0 : r_g + 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
      // Placed after the save so a clear of the same channel wins.
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ctx_clr[i]) r_ctx[i] <= 2'b00;
      end
    end
  end

  assign gnt       = r_gnt;
  assign out_valid = r_valid;
  assign out_ch    = r_out_ch;
  assign out_state = r_out_state;
  assign out_y     = r_out_y;

`ifdef SEQ_CTX_SCHED_STATS_EN
  logic [15:0] r_stat [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) r_stat[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ctx_clr[i]) r_stat[i] <= '0;
        else if (r_valid && r_out_y && (r_out_ch == CW'(i)) && (r_stat[i] != '1))
          r_stat[i] <= r_stat[i] + 16'd1;
      end
    end
  end

  assign stat_cnt = (32'(stat_sel) < N_CH) ? r_stat[stat_sel] : '0;
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^stat_sel;
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_ctx_sched.sv
// Self-checking bench for seq_ctx_sched: vector table, directed corner sequences, randomized run vs model.
module tb_seq_ctx_sched;
  localparam int MB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req, bit_in, last, ctx_clr, gnt;
  logic       out_valid, out_y;
  logic [1:0] out_ch, out_state, stat_sel;
  logic [15:0] stat_cnt;

  logic [3:0] req2, bit2, last2, clr2, gnt2;
  logic       ov2, oy2;
  logic [1:0] och2, ost2, ssel2;
  logic [15:0] scnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_ctx_sched #(.N_CH(4), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bit_in(bit_in), .last(last), .ctx_clr(ctx_clr),
    .gnt(gnt), .out_valid(out_valid), .out_ch(out_ch), .out_state(out_state), .out_y(out_y),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt));

  seq_ctx_sched #(.N_CH(4), .MAX_BURST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .bit_in(bit2), .last(last2), .ctx_clr(clr2),
    .gnt(gnt2), .out_valid(ov2), .out_ch(och2), .out_state(ost2), .out_y(oy2),
    .stat_sel(ssel2), .stat_cnt(scnt2));

  typedef struct {
    logic [3:0] req, bits, last, gnt;
    logic       v;
    logic [1:0] st;
    logic       y;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence rule: C=1 goes to 01/10 by the old high bit, C=0 to 00/11 by the old low bit.
  function automatic logic [1:0] ref_fsm(input logic [1:0] s, input logic c);
    if (c) return s[1] ? 2'b10 : 2'b01;
    return s[0] ? 2'b11 : 2'b00;
  endfunction

  task automatic burst(input int ch, input logic [7:0] bits, input int n,
                       input logic [15:0] exp, input string tag);
    int t;
    req[ch] = 1'b1; bit_in[ch] = bits[0]; last[ch] = (n == 1);
    t = 0;
    @(negedge clk);
    while (!gnt[ch] && t < 20) begin @(negedge clk); t++; end
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << ch);
    if (!gnt[ch]) begin req[ch] = 1'b0; last[ch] = 1'b0; return; end
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k + 1 < n) begin bit_in[ch] = bits[k+1]; last[ch] = (k + 2 == n); end
      else begin req[ch] = 1'b0; last[ch] = 1'b0; end
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_ch"}, 32'(out_ch), 32'(ch));
      chk({tag, "_state"}, 32'(out_state), 32'(exp[2*k +: 2]));
      chk({tag, "_y"}, 32'(out_y), 32'(exp[2*k +: 2] == 2'b11));
      chk({tag, "_gnt_hold"}, 32'(gnt[ch]), 32'(k + 1 < n));
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   t, nb, blen, g, rr, zr, bcnt, expch, pch;
    int   ord[5];
    logic [3:0] pg, egnt;
    logic [1:0] mctx[4];
    logic [1:0] pst;
    bit   mload, pv;

    // ch0 sends 1,0,0 (last on third): IDLE, LOAD, 3x RUN, SAVE, IDLE.
    tbl[0] = '{4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0};
    tbl[1] = '{4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0};
    tbl[2] = '{4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'b00, 1'b0};
    tbl[3] = '{4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 2'b01, 1'b0};
    tbl[4] = '{4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 2'b11, 1'b1};
    tbl[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'b11, 1'b1};
    tbl[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0};

    req = '0; bit_in = '0; last = '0; ctx_clr = '0; stat_sel = '0;
    req2 = '0; bit2 = '0; last2 = '0; clr2 = '0; ssel2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_out_state", 32'(out_state), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_stat", 32'(stat_cnt), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_valid", 32'(out_valid), 0);
    end

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      req = tbl[i].req; bit_in = tbl[i].bits; last = tbl[i].last;
      @(negedge clk);
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("tbl_ch", 32'(out_ch), 0);
        chk("tbl_state", 32'(out_state), 32'(tbl[i].st));
        chk("tbl_y", 32'(out_y), 32'(tbl[i].y));
      end
    end

    burst(1, 8'h01, 2, 16'h000D, "ctx_a");
    burst(2, 8'h01, 1, 16'h0001, "ctx_b");
    burst(1, 8'h01, 1, 16'h0002, "ctx_c");

    burst(1, 8'h01, 1, 16'h0002, "clr_a");
    ctx_clr = 4'b0010;
    @(posedge clk); #1 ctx_clr = '0;
    burst(1, 8'h01, 1, 16'h0001, "clr_b");

    req[2] = 1'b1; bit_in[2] = 1'b1; last[2] = 1'b0;
    t = 0;
    @(negedge clk);
    while (!gnt[2] && t < 20) begin @(negedge clk); t++; end
    chk("drop_gnt", 32'(gnt), 32'h4);
    @(posedge clk); #1 req[2] = 1'b0;
    @(negedge clk);
    chk("drop_valid1", 32'(out_valid), 1);
    chk("drop_state1", 32'(out_state), 32'h1);
    chk("drop_gnt_run", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_valid2", 32'(out_valid), 0);
    chk("drop_gnt_save", 32'(gnt), 0);
    burst(2, 8'h00, 1, 16'h0003, "drop_c");

    req2 = 4'hF; nb = 0; blen = 0; pg = '0; t = 0;
    for (int i = 0; i < 5; i++) ord[i] = 99;
    while (nb < 5 && t < 80) begin
      @(posedge clk); #1 bit2 = 4'($urandom);
      @(negedge clk); t++;
      chk("fair_onehot", 32'((gnt2 & (gnt2 - 4'd1)) == 4'd0), 1);
      if (gnt2 != '0 && pg == '0) begin
        for (int i = 0; i < 4; i++) if (gnt2[i]) ord[nb] = i;
        blen = 0;
      end
      if ((gnt2 & req2) != '0) blen++;
      if (gnt2 == '0 && pg != '0) begin chk("fair_len", 32'(blen), 2); nb++; end
      pg = gnt2;
    end
    req2 = '0;
    chk("fair_bursts", 32'(nb), 5);
    for (int i = 0; i < 5; i++) chk("fair_order", 32'(ord[i]), 32'(i % 4));

    burst(3, 8'h01, 6, 16'h0FFD, "stat");
    repeat (2) @(posedge clk);
    #1 stat_sel = 2'd3;
    #1;
`ifdef SEQ_CTX_SCHED_STATS_EN
    chk("stat_cnt5", 32'(stat_cnt), 5);
`else
    chk("stat_cnt_off", 32'(stat_cnt), 0);
`endif
    ctx_clr = 4'b1000;
    @(posedge clk); #1 ctx_clr = '0;
    @(negedge clk);
    chk("stat_clr", 32'(stat_cnt), 0);

    req[0] = 1'b1; bit_in[0] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!gnt[0] && t < 20) begin @(negedge clk); t++; end
    chk("mrst_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mrst_gnt0", 32'(gnt), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_state", 32'(out_state), 0);
    chk("mrst_stat", 32'(stat_cnt), 0);
    req = '0; bit_in = '0; last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) mctx[i] = 2'b00;
    rr = 0; zr = 1; bcnt = 0; expch = 0; mload = 0; egnt = '0; pv = 0; pch = 0; pst = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        bit_in[i] = 1'($urandom_range(0, 1));
        last[i]   = ($urandom_range(0, 5) == 0);
      end
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(pv));
      if (pv) begin
        chk("rnd_ch", 32'(out_ch), 32'(pch));
        chk("rnd_state", 32'(out_state), 32'(pst));
        chk("rnd_y", 32'(out_y), 32'(pst == 2'b11));
      end
      chk("rnd_gnt", 32'(gnt), 32'(egnt));
      pv = 0;
      if (egnt != '0) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (egnt[i]) g = i;
        if (req[g]) begin
          mctx[g] = ref_fsm(mctx[g], bit_in[g]);
          pv = 1; pch = g; pst = mctx[g]; bcnt++;
        end
        if (!req[g] || last[g] || bcnt == MB) begin
          egnt = '0; rr = (g + 1) % 4; zr = 0;
        end
      end else begin
        zr++;
        if (mload) begin
          mload = 0; egnt = 4'(1) << expch; bcnt = 0;
        end else if (zr >= 2 && req != '0) begin
          mload = 1;
          for (int k = 3; k >= 0; k--) if (req[(rr + k) % 4]) expch = (rr + k) % 4;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
